// File: rtl/speck_share_serdes.sv
// Loads SHARES-way masked pt/key bit-serially into a threshold Speck core, runs it, and packs the 2-bit/share cipher stream back.
// Accept to out_valid is KEY_W+RUN_CYCLES cycles; busy while a block is in flight, and out_valid holds until out_ready.
module speck_share_serdes #(
  parameter int SHARES     = 2,
  parameter int BLOCK_W    = 128,
  parameter int KEY_W      = 128,
  parameter int RUN_CYCLES = 30000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SHARES*BLOCK_W-1:0]   pt_sh,
  input  logic [SHARES*KEY_W-1:0]     key_sh,
  output logic [SHARES-1:0]           core_data,
  output logic [SHARES-1:0]           core_kdata,
  output logic [SHARES-1:0]           core_carry_init,
  output logic                        core_we,
  output logic                        core_start,
  input  logic [2*SHARES-1:0]         core_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SHARES*BLOCK_W-1:0]   ct_sh
);

  localparam int CNT_MAX = (KEY_W > RUN_CYCLES) ? KEY_W : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(RUN_CYCLES - BLOCK_W/2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [SHARES*BLOCK_W-1:0]  pt_sr, pt_sr_nxt, ct_nxt;
  logic [SHARES*KEY_W-1:0]    key_sr, key_sr_nxt;
  logic [SHARES-1:0]          data_nxt, kdata_nxt;
  logic                       in_ready_nxt, we_nxt, start_nxt, out_valid_nxt;

  // Only share 0 carries the constant +1 of the masked adder.
  assign core_carry_init = SHARES'(1);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pt_sr_nxt     = pt_sr;
    key_sr_nxt    = key_sr;
    ct_nxt        = ct_sh;
    data_nxt      = '0;
    kdata_nxt     = '0;
    in_ready_nxt  = in_ready;
    we_nxt        = 1'b0;
    start_nxt     = 1'b0;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt    = LOAD;
          cnt_nxt      = '0;
          in_ready_nxt = 1'b0;
          we_nxt       = 1'b1;
          // Bit 0 goes straight to the output register; the rest waits in the shifters.
          for (int s = 0; s < SHARES; s++) begin
            data_nxt[s]                       = pt_sh[s*BLOCK_W];
            kdata_nxt[s]                      = key_sh[s*KEY_W];
            pt_sr_nxt[s*BLOCK_W +: BLOCK_W]   = pt_sh[s*BLOCK_W +: BLOCK_W] >> 1;
            key_sr_nxt[s*KEY_W +: KEY_W]      = key_sh[s*KEY_W +: KEY_W] >> 1;
          end
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          start_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          we_nxt  = 1'b1;
          // Zero-fill makes the data lines idle once the block width is exhausted.
          for (int s = 0; s < SHARES; s++) begin
            data_nxt[s]                     = pt_sr[s*BLOCK_W];
            kdata_nxt[s]                    = key_sr[s*KEY_W];
            pt_sr_nxt[s*BLOCK_W +: BLOCK_W] = pt_sr[s*BLOCK_W +: BLOCK_W] >> 1;
            key_sr_nxt[s*KEY_W +: KEY_W]    = key_sr[s*KEY_W +: KEY_W] >> 1;
          end
        end
      end
      RUN: begin
        if (cnt >= CAP_FIRST) begin
          for (int s = 0; s < SHARES; s++) begin
            ct_nxt[s*BLOCK_W +: BLOCK_W] = {core_cout[2*s +: 2], ct_sh[s*BLOCK_W+2 +: BLOCK_W-2]};
          end
        end
        if (cnt == RUN_LAST) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          start_nxt = 1'b1;
        end
      end
      DONE: begin
        out_valid_nxt = 1'b1;
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pt_sr      <= '0;
      key_sr     <= '0;
      ct_sh      <= '0;
      core_data  <= '0;
      core_kdata <= '0;
      in_ready   <= 1'b1;
      core_we    <= 1'b0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pt_sr      <= pt_sr_nxt;
      key_sr     <= key_sr_nxt;
      ct_sh      <= ct_nxt;
      core_data  <= data_nxt;
      core_kdata <= kdata_nxt;
      in_ready   <= in_ready_nxt;
      core_we    <= we_nxt;
      core_start <= start_nxt;
      out_valid  <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_speck_share_serdes.sv
// Bench for speck_share_serdes: a 2-share 128/128 instance and a 3-share 128/256 instance against a cycle-index model.
module tb_speck_share_serdes;
  localparam int BW    = 128;
  localparam int KW_A  = 128;
  localparam int RUN_A = 100;
  localparam int KW_B  = 256;
  localparam int RUN_B = 80;

  localparam logic [127:0] PT   = 128'h6c617669757165207469206564616d20;
  localparam logic [127:0] KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT0  = {16{8'he4}};
  localparam logic [127:0] CT1  = {16{8'h39}};
  localparam logic [127:0] CT2  = {16{8'h4e}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv [2];
  logic         ordy [2];
  logic [383:0] ptv [2];
  logic [767:0] keyv [2];
  logic [5:0]   coutv [2];

  logic         a_ir, a_we, a_st, a_ov;
  logic [1:0]   a_d, a_kd, a_ci;
  logic [255:0] a_ct;
  logic         b_ir, b_we, b_st, b_ov;
  logic [2:0]   b_d, b_kd, b_ci;
  logic [383:0] b_ct;

  speck_share_serdes #(.SHARES(2), .BLOCK_W(BW), .KEY_W(KW_A), .RUN_CYCLES(RUN_A)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(a_ir),
    .pt_sh(ptv[0][255:0]), .key_sh(keyv[0][255:0]),
    .core_data(a_d), .core_kdata(a_kd), .core_carry_init(a_ci),
    .core_we(a_we), .core_start(a_st), .core_cout(coutv[0][3:0]),
    .out_valid(a_ov), .out_ready(ordy[0]), .ct_sh(a_ct));

  speck_share_serdes #(.SHARES(3), .BLOCK_W(BW), .KEY_W(KW_B), .RUN_CYCLES(RUN_B)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(b_ir),
    .pt_sh(ptv[1]), .key_sh(keyv[1]),
    .core_data(b_d), .core_kdata(b_kd), .core_carry_init(b_ci),
    .core_we(b_we), .core_start(b_st), .core_cout(coutv[1]),
    .out_valid(b_ov), .out_ready(ordy[1]), .ct_sh(b_ct));

  // Uniform 3-share views of both instances.
  logic         v_ir [2], v_we [2], v_st [2], v_ov [2];
  logic [2:0]   v_d [2], v_kd [2];
  logic [383:0] v_ct [2];
  always_comb begin
    v_ir[0] = a_ir;  v_we[0] = a_we;  v_st[0] = a_st;  v_ov[0] = a_ov;
    v_d[0]  = {1'b0, a_d};  v_kd[0] = {1'b0, a_kd};  v_ct[0] = {128'b0, a_ct};
    v_ir[1] = b_ir;  v_we[1] = b_we;  v_st[1] = b_st;  v_ov[1] = b_ov;
    v_d[1]  = b_d;   v_kd[1] = b_kd;  v_ct[1] = b_ct;
  end

  int total, bad;
  bit chk_on;

  task automatic chk(input string nm, input int id, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  function automatic int kwf(input int id);   return (id == 0) ? KW_A  : KW_B;  endfunction
  function automatic int rnf(input int id);   return (id == 0) ? RUN_A : RUN_B; endfunction
  function automatic int nshf(input int id);  return (id == 0) ? 2 : 3;         endfunction
  function automatic logic [1:0] pat(input int s, input int j); return 2'((j + s) % 4); endfunction

  function automatic logic [383:0] exp_ct(input int id);
    logic [383:0] r;
    r = '0;
    for (int s = 0; s < nshf(id); s++)
      for (int j = 0; j < BW/2; j++)
        r[s*BW + 2*j +: 2] = pat(s, j);
    return r;
  endfunction

  // Model: m_k is the cycle index since the accept edge.
  bit           m_busy [2], m_ov [2];
  int           m_k [2];
  logic [127:0] m_pt [2][3];
  logic [255:0] m_key [2][3];
  logic [383:0] m_ct [2];

  initial forever begin
    @(posedge clk);
    for (int id = 0; id < 2; id++) begin
      if (!rst_n) begin
        m_busy[id] = 0; m_ov[id] = 0; m_k[id] = 0; m_ct[id] = '0;
      end else if (!m_busy[id]) begin
        if (iv[id]) begin
          m_busy[id] = 1; m_ov[id] = 0; m_k[id] = 0;
          for (int s = 0; s < 3; s++) begin
            m_pt[id][s] = ptv[id][s*BW +: BW];
            if (id == 0) m_key[id][s] = (s < 2) ? {128'b0, keyv[0][s*KW_A +: KW_A]} : 256'b0;
            else         m_key[id][s] = keyv[1][s*KW_B +: KW_B];
          end
        end
      end else if (m_ov[id]) begin
        if (ordy[id]) begin m_busy[id] = 0; m_ov[id] = 0; end
      end else begin
        m_k[id]++;
        if (m_k[id] == kwf(id) + rnf(id)) begin m_ov[id] = 1; m_ct[id] = exp_ct(id); end
      end
    end
  end

  // Core stub: pattern inside the capture window, noise everywhere else.
  initial forever begin
    @(negedge clk);
    #2;
    for (int id = 0; id < 2; id++) begin
      int j;
      coutv[id] = 6'($urandom);
      if (m_busy[id] && !m_ov[id]) begin
        j = m_k[id] - (kwf(id) + rnf(id) - BW/2);
        if (j >= 0 && j < BW/2)
          for (int s = 0; s < 3; s++) coutv[id][2*s +: 2] = pat(s, j);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int id = 0; id < 2; id++) begin
        logic       e_we, e_st;
        logic [2:0] e_d, e_kd;
        int         kk;
        e_we = 0; e_st = 0; e_d = '0; e_kd = '0; kk = m_k[id];
        if (m_busy[id] && !m_ov[id]) begin
          if (kk < kwf(id)) begin
            e_we = 1;
            for (int s = 0; s < nshf(id); s++) begin
              e_kd[s] = m_key[id][s][kk];
              if (kk < BW) e_d[s] = m_pt[id][s][kk];
            end
          end else e_st = 1;
        end
        chk("in_ready",   id, v_ir[id], !m_busy[id]);
        chk("out_valid",  id, v_ov[id], m_ov[id]);
        chk("core_we",    id, v_we[id], e_we);
        chk("core_start", id, v_st[id], e_st);
        chk("core_data",  id, v_d[id],  e_d);
        chk("core_kdata", id, v_kd[id], e_kd);
        if (!(m_busy[id] && !m_ov[id] && kk > kwf(id) + rnf(id) - BW/2))
          chk("ct_sh", id, v_ct[id], m_ct[id]);
      end
    end
  end

  int           lat, wecnt;
  logic [255:0] rx_d0, rx_x, rx_k0;
  logic         sh1_or, hi_or;

  task automatic start_req(input int id, input logic [383:0] pt, input logic [767:0] key);
    int n;
    n = 0;
    while (v_ir[id] !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
    chk("ready_wait", id, v_ir[id], 1'b1);
    ptv[id] = pt; keyv[id] = key; iv[id] = 1'b1;
    @(posedge clk); #1;
    iv[id] = 1'b0;
  endtask

  task automatic xfer(input int id, input logic [383:0] pt, input logic [767:0] key,
                      input bit toggle, input int hold);
    int n;
    bit ovs;
    if (hold > 0) ordy[id] = 1'b0;
    start_req(id, pt, key);
    wecnt = 0; rx_d0 = '0; rx_x = '0; rx_k0 = '0; sh1_or = 0; hi_or = 0;
    n = 0; ovs = 0;
    while (!ovs && n < 3000) begin
      @(negedge clk);
      n++;
      if (v_ov[id] === 1'b1) ovs = 1;
      if (v_we[id] === 1'b1) begin
        if (wecnt < 256) begin
          rx_d0[wecnt] = v_d[id][0];
          rx_x[wecnt]  = ^v_d[id];
          rx_k0[wecnt] = v_kd[id][0];
        end
        if (wecnt >= BW) hi_or = hi_or | (|v_d[id]);
        sh1_or = sh1_or | v_d[id][1] | v_kd[id][1];
        wecnt++;
      end
      #1;
      if (toggle) iv[id] = n[0];
    end
    lat = n - 1;
    chk("out_valid_wait", id, ovs, 1'b1);
    repeat (hold) @(negedge clk);
    #1;
    ordy[id] = 1'b1;
    if (toggle) iv[id] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] m, m2, mk;
    int n;
    rst_n = 1'b0; chk_on = 0; total = 0; bad = 0;
    for (int id = 0; id < 2; id++) begin
      iv[id] = 1'b0; ordy[id] = 1'b1; ptv[id] = '0; keyv[id] = '0;
    end
    @(posedge clk); #1;
    chk_on = 1;
    @(negedge clk);
    chk("rst_in_ready", 0, a_ir, 1'b1);
    chk("rst_we",       0, a_we, 1'b0);
    chk("rst_ct",       0, a_ct, '0);
    chk("rst_ct",       1, b_ct, '0);
    chk("carry_init",   0, a_ci, 2'b01);
    chk("carry_init",   1, b_ci, 3'b001);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain 2-share load and literal stream check.
    xfer(0, {256'b0, PT}, {640'b0, KEY}, 0, 0);
    chk("pt_stream",  0, rx_d0[127:0], PT);
    chk("key_stream", 0, rx_k0[127:0], KEY);
    chk("share1_idle", 0, sh1_or, 1'b0);
    chk("we_cycles",  0, wecnt, 128);
    chk("latency",    0, lat, 228);
    chk("ct_literal", 0, a_ct, {CT1, CT0});

    // Masked load: shares must recombine to PT on every load cycle.
    m  = {$urandom, $urandom, $urandom, $urandom};
    mk = {$urandom, $urandom, $urandom, $urandom};
    xfer(0, {128'b0, m, PT ^ m}, {512'b0, mk, KEY ^ mk}, 0, 0);
    chk("masked_xor", 0, rx_x[127:0], PT);
    chk("latency",    0, lat, 228);

    // Three shares with a 256-bit key.
    m2 = {$urandom, $urandom, $urandom, $urandom};
    xfer(1, {m2, m, PT ^ m ^ m2}, {512'b0, ~KEY, KEY}, 0, 0);
    chk("we_cycles",   1, wecnt, 256);
    chk("data_tail0",  1, hi_or, 1'b0);
    chk("masked_xor",  1, rx_x[127:0], PT);
    chk("key_stream",  1, rx_k0, {~KEY, KEY});
    chk("latency",     1, lat, 336);
    chk("ct_literal",  1, b_ct, {CT2, CT1, CT0});

    // Backpressure in DONE with in_valid toggling throughout.
    xfer(0, {256'b0, PT2}, {640'b0, KEY}, 1, 10);
    chk("latency", 0, lat, 228);
    @(negedge clk);
    chk("no_accept_on_handshake", 0, {a_ir, a_we}, 2'b10);
    #1;
    @(negedge clk);
    chk("accept_after_ready", 0, {a_ir, a_we}, 2'b01);
    #1;
    iv[0] = 1'b0;
    n = 0;
    while (a_ir !== 1'b1 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("drain", 0, a_ir, 1'b1);

    // Reset on LOAD cycle 50.
    start_req(0, {256'b0, PT}, {640'b0, KEY});
    repeat (51) @(negedge clk);
    chk("mid_load", 0, a_we, 1'b1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_we_st", 0, {a_we, a_st}, 2'b00);
    chk("rst_load_ready", 0, a_ir, 1'b1);
    chk("rst_load_ct",    0, a_ct, '0);
    chk("rst_load_ct",    1, b_ct, '0);
    #1;
    xfer(0, {256'b0, PT}, {640'b0, KEY}, 0, 0);
    chk("latency",    0, lat, 228);
    chk("ct_literal", 0, a_ct, {CT1, CT0});

    // Reset on a RUN cycle.
    start_req(0, {256'b0, PT}, {640'b0, KEY});
    repeat (KW_A + 31) @(negedge clk);
    chk("mid_run", 0, a_st, 1'b1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_run_we_st", 0, {a_we, a_st}, 2'b00);
    chk("rst_run_ready", 0, a_ir, 1'b1);
    chk("rst_run_ct",    0, a_ct, '0);
    #1;
    xfer(0, {256'b0, PT}, {640'b0, KEY}, 0, 0);
    chk("latency",    0, lat, 228);
    chk("ct_literal", 0, a_ct, {CT1, CT0});

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speck_share_serdes.md
# speck_share_serdes

Parametrised share loader/unloader for the team's bit-serial threshold-implementation Speck cores. It accepts a word-parallel, SHARES-way masked plaintext and key over a valid/ready handshake and serialises them LSB-first into the core's per-share `data_in*`/`k_data_in*` lines under `we`. It then holds `Start` for a fixed run window, captures the core's 2-bit-per-share cipher stream back into parallel shares, and presents the result on a valid/ready handshake. It replaces the hand-driven load/start sequencing used in the 2-share and 3-share core benches and sits between the system bus wrapper and the core.

## Interface
Parameters:
- SHARES, 2: number of Boolean shares; legal values are 2 and 3.
- BLOCK_W, 128: cipher block width. Must be even.
- KEY_W, 128: key width. Must satisfy KEY_W >= BLOCK_W.
- RUN_CYCLES, 30000: number of cycles `core_start` is held high. Must satisfy RUN_CYCLES >= BLOCK_W/2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle; request can be accepted.
- pt_sh  in  SHARES*BLOCK_W  plaintext shares; share s occupies [s*BLOCK_W +: BLOCK_W].
- key_sh  in  SHARES*KEY_W  key shares; share s occupies [s*KEY_W +: KEY_W].
- core_data  out  SHARES  serial plaintext bit, one per share.
- core_kdata  out  SHARES  serial key bit, one per share.
- core_carry_init  out  SHARES  per-share carry initialisation; constant, bit 0 = 1, all other bits 0.
- core_we  out  1  core load enable.
- core_start  out  1  core run enable.
- core_cout  in  SHARES*2  cipher output pair for share s on [2s +: 2].
- out_valid  out  1  ciphertext shares valid.
- out_ready  in  1  consumer accepts the ciphertext.
- ct_sh  out  SHARES*BLOCK_W  ciphertext shares, packed with the same layout as `pt_sh`.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Counter `cnt` is wide enough to hold max(KEY_W, RUN_CYCLES).
- IDLE:
  - `in_ready` = 1.
  - `in_valid & in_ready` latches `pt_sh` and `key_sh` into internal shift registers, clears `cnt`, and moves to LOAD.
  - Inputs not accepted are ignored.
- LOAD:
  - `core_we` = 1 for exactly KEY_W cycles.
  - On load cycle k, `core_kdata[s]` = key share s bit k.
  - On load cycle k, `core_data[s]` = pt share s bit k for k < BLOCK_W, and 0 otherwise.
  - After cycle KEY_W-1, move to RUN.
- RUN:
  - `core_start` = 1 for exactly RUN_CYCLES cycles; `core_we` = 0; data lines = 0.
  - Capture window is the last BLOCK_W/2 RUN cycles. On window cycle j (0-based), `core_cout[2s +: 2]` is written to ct share s bits [2j+1:2j].
  - After the last RUN cycle, move to DONE.
- DONE:
  - `out_valid` = 1; `ct_sh` is stable.
  - `out_valid & out_ready` moves the FSM to IDLE.
  - `ct_sh` keeps its value until the next capture window writes it.
- `ct_sh` is written only inside the capture window. The block never recombines shares.
- Reset (any state, including mid-LOAD or mid-RUN) returns the FSM to IDLE and clears `cnt`, the shift registers and `ct_sh`.

## Timing
- All outputs are registered.
- Reset values: `in_ready` = 1, `core_carry_init` = {0…01}; every other output = 0, including `ct_sh`.
- Accept edge E0:
  - `core_we` = 1 with bit 0 from E0 through E(KEY_W).
  - `core_start` = 1 from E(KEY_W) through E(KEY_W+RUN_CYCLES).
  - `out_valid` rises at E(KEY_W+RUN_CYCLES).
- `in_ready` falls at E0 and rises again on the edge after the `out_valid & out_ready` handshake. An output handshake and an input accept never occur in the same cycle.
- `core_we` and `core_start` are never high in the same cycle. There is no gap cycle between LOAD and RUN.
- Minimum request-to-request interval: KEY_W + RUN_CYCLES + 2 cycles.

## Test plan
- Load, SHARES=2, 128/128:
  - Stimulus: share0 pt = 6c617669757165207469206564616d20, key = 0f0e0d0c0b0a09080706050403020100; share1 = 0.
  - Required: `core_data[0]` bit-serial matches pt LSB-first over 128 cycles with `core_we` = 1; share-1 lines are all 0; `core_carry_init` = 2'b01.
- Masked load:
  - Stimulus: random mask M; share0 = pt^M, share1 = M.
  - Required: on every load cycle, `core_data[0]^core_data[1]` = pt bit k.
- Capture, RUN_CYCLES=100:
  - Stimulus: stub drives `core_cout` = j[1:0] on window cycle j.
  - Required: `ct_sh` matches the expected pattern; `out_valid` rises exactly 228 cycles after accept.
- SHARES=3, KEY_W=256, BLOCK_W=128:
  - Required: `core_we` is high for 256 cycles; data lines = 0 on cycles 128–255.
- Backpressure and ignore:
  - Stimulus: hold `out_ready` = 0 for 10 cycles in DONE; toggle `in_valid` while busy.
  - Required: `ct_sh` and `out_valid` hold; no second accept occurs; the next request is taken only once `in_ready` = 1.
- Reset mid-operation:
  - Stimulus: pull `rst_n` low on LOAD cycle 50, and separately on a RUN cycle.
  - Required: the next cycle shows `core_we` = `core_start` = 0, `in_ready` = 1 and `ct_sh` = 0; a fresh request then completes normally.
